// File: rtl/dmem_arb_pkg.sv
// Shared types, defaults and the address-range check for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {IDLE, RESP} state_e;

  typedef logic port_idx_t;

  localparam logic [31:0] DMEM_BASE_ADDR_DEF = 32'h8000_0000;

  // 33-bit offset so addresses below base show up as a borrow instead of wrapping.
  function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] base,
                                   input int unsigned size);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, base};
    return (addr[1:0] == 2'b00) && !off[32] && ({2'b00, off[31:2]} < size);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the port that did not win last time is granted.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  port_idx_t rr_last_q, rr_last_d;

  always_comb begin
    gnt_o     = 2'b00;
    rr_last_d = rr_last_q;
    if (en_i) begin
      if (req_i == 2'b11) begin
        gnt_o = rr_last_q ? 2'b01 : 2'b10;
      end else begin
        gnt_o = req_i;
      end
    end
    if (|gnt_o) begin
      rr_last_d = gnt_o[1];
    end
  end

  // Reset to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin front end for the word-addressed data memory with a registered response.
// Optional grant/error counters are built when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MEM_SIZE  = 2000,
  parameter logic [31:0] BASE_ADDR = DMEM_BASE_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
`ifdef DMEM_ARB_PERF_EN
  output logic [31:0] perf_grant0,
  output logic [31:0] perf_grant1,
  output logic [31:0] perf_err,
`endif
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic [31:0] m0_req_addr,
  input  logic        m0_req_we,
  input  logic [31:0] m0_req_wdata,
  output logic        m0_rsp_valid,
  input  logic        m0_rsp_ready,
  output logic [31:0] m0_rsp_rdata,
  output logic        m0_rsp_err,
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic [31:0] m1_req_addr,
  input  logic        m1_req_we,
  input  logic [31:0] m1_req_wdata,
  output logic        m1_rsp_valid,
  input  logic        m1_rsp_ready,
  output logic [31:0] m1_rsp_rdata,
  output logic        m1_rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  port_idx_t   owner_q, owner_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [1:0]  gnt;
  logic        granted, owner_ready, can_accept, ok;
  port_idx_t   gnt_idx;
  logic [31:0] sel_addr, sel_wdata;
  logic        sel_we;

  assign owner_ready = owner_q ? m1_rsp_ready : m0_rsp_ready;
  assign can_accept  = (state_q == IDLE) || owner_ready;

  rr_arb2 u_rr_arb2 (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (can_accept && !rst),
    .req_i ({m1_req_valid, m0_req_valid}),
    .gnt_o (gnt)
  );

  assign granted   = |gnt;
  assign gnt_idx   = gnt[1];
  assign sel_addr  = gnt_idx ? m1_req_addr : m0_req_addr;
  assign sel_wdata = gnt_idx ? m1_req_wdata : m0_req_wdata;
  assign sel_we    = gnt_idx ? m1_req_we : m0_req_we;
  assign ok        = addr_ok(sel_addr, BASE_ADDR, MEM_SIZE);

  assign m0_req_ready = gnt[0];
  assign m1_req_ready = gnt[1];
  assign mem_addr     = granted ? sel_addr : '0;
  assign mem_wdata    = granted ? sel_wdata : '0;
  assign mem_we       = granted && sel_we && ok;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (granted) begin
      // A new grant also retires the held response when the owner is ready.
      state_d = RESP;
      owner_d = gnt_idx;
      rdata_d = (!sel_we && ok) ? mem_rdata : '0;
      err_d   = !ok;
    end else if (state_q == RESP && owner_ready) begin
      state_d = IDLE;
      rdata_d = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign m0_rsp_valid = (state_q == RESP) && (owner_q == 1'b0);
  assign m1_rsp_valid = (state_q == RESP) && (owner_q == 1'b1);
  assign m0_rsp_rdata = m0_rsp_valid ? rdata_q : '0;
  assign m1_rsp_rdata = m1_rsp_valid ? rdata_q : '0;
  assign m0_rsp_err   = m0_rsp_valid && err_q;
  assign m1_rsp_err   = m1_rsp_valid && err_q;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] grant0_q, grant1_q, err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      grant0_q  <= '0;
      grant1_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      if (gnt[0] && grant0_q != '1) grant0_q <= grant0_q + 32'd1;
      if (gnt[1] && grant1_q != '1) grant1_q <= grant1_q + 32'd1;
      if (granted && !ok && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 32'd1;
    end
  end

  assign perf_grant0 = grant0_q;
  assign perf_grant1 = grant1_q;
  assign perf_err    = err_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int unsigned MEM_SIZE = 2000;
  localparam logic [31:0] BASE     = 32'h8000_0000;

  logic        clk, rst;
  logic        m0_req_valid, m0_req_ready, m0_req_we, m0_rsp_valid, m0_rsp_ready, m0_rsp_err;
  logic [31:0] m0_req_addr, m0_req_wdata, m0_rsp_rdata;
  logic        m1_req_valid, m1_req_ready, m1_req_we, m1_rsp_valid, m1_rsp_ready, m1_rsp_err;
  logic [31:0] m1_req_addr, m1_req_wdata, m1_rsp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_grant0, perf_grant1, perf_err;
`endif

  dmem_arbiter #(.MEM_SIZE(MEM_SIZE), .BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef DMEM_ARB_PERF_EN
    .perf_grant0  (perf_grant0),
    .perf_grant1  (perf_grant1),
    .perf_err     (perf_err),
`endif
    .m0_req_valid (m0_req_valid),
    .m0_req_ready (m0_req_ready),
    .m0_req_addr  (m0_req_addr),
    .m0_req_we    (m0_req_we),
    .m0_req_wdata (m0_req_wdata),
    .m0_rsp_valid (m0_rsp_valid),
    .m0_rsp_ready (m0_rsp_ready),
    .m0_rsp_rdata (m0_rsp_rdata),
    .m0_rsp_err   (m0_rsp_err),
    .m1_req_valid (m1_req_valid),
    .m1_req_ready (m1_req_ready),
    .m1_req_addr  (m1_req_addr),
    .m1_req_we    (m1_req_we),
    .m1_req_wdata (m1_req_wdata),
    .m1_rsp_valid (m1_rsp_valid),
    .m1_rsp_ready (m1_rsp_ready),
    .m1_rsp_rdata (m1_rsp_rdata),
    .m1_rsp_err   (m1_rsp_err),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory stub: combinational read, write on the clock edge.
  logic [31:0] mem [MEM_SIZE] = '{default: 32'h0};
  logic [31:0] mem_off;
  assign mem_off   = mem_addr - BASE;
  assign mem_rdata = (mem_addr >= BASE && mem_off[31:2] < 30'(MEM_SIZE)) ? mem[mem_off[31:2]] : '0;
  always @(posedge clk) begin
    if (mem_we && mem_addr >= BASE && mem_off[31:2] < 30'(MEM_SIZE)) mem[mem_off[31:2]] <= mem_wdata;
  end

  // Reference model: one outstanding response, last-winner memory, shadow memory, counters.
  logic [31:0] model_mem [MEM_SIZE] = '{default: 32'h0};
  bit          m_busy;
  int          m_owner, m_last, last_g;
  logic [31:0] m_rdata;
  bit          m_err;
  int unsigned p_g0, p_g1, p_err;
  int          nvec, nfail;

  function automatic bit m_ok(input logic [31:0] a);
    longint unsigned la = a;
    return (la % 4 == 0) && (la >= longint'(BASE)) && ((la - BASE) / 4 < MEM_SIZE);
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      6:       return BASE + 4 * (MEM_SIZE - 1);
      7:       return BASE + 4 * $urandom_range(0, 7) + $urandom_range(1, 3);
      8:       return BASE - 4 * $urandom_range(1, 4);
      9:       return BASE + 4 * MEM_SIZE + 4 * $urandom_range(0, 3);
      default: return BASE + 4 * $urandom_range(0, 7);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: inputs already driven at the falling edge; check, clock, advance the model.
  task automatic step();
    int          g;
    bit          ok, gw, can;
    logic [31:0] ga, gd;
    #1;
    check("m0_rsp_valid", 32'(m_busy && m_owner == 0), 32'(m0_rsp_valid));
    check("m1_rsp_valid", 32'(m_busy && m_owner == 1), 32'(m1_rsp_valid));
    if (m_busy) begin
      check("rsp_rdata", m_owner == 0 ? m0_rsp_rdata : m1_rsp_rdata, m_rdata);
      check("rsp_err", 32'(m_owner == 0 ? m0_rsp_err : m1_rsp_err), 32'(m_err));
    end
    can = !m_busy || (m_owner == 0 ? m0_rsp_ready : m1_rsp_ready);
    g = -1;
    if (!rst && can) begin
      if (m0_req_valid && m1_req_valid) g = (m_last == 0) ? 1 : 0;
      else if (m0_req_valid) g = 0;
      else if (m1_req_valid) g = 1;
    end
    ga = (g == 1) ? m1_req_addr : m0_req_addr;
    gd = (g == 1) ? m1_req_wdata : m0_req_wdata;
    gw = (g == 1) ? m1_req_we : m0_req_we;
    ok = m_ok(ga);
    check("m0_req_ready", 32'(m0_req_ready), 32'(g == 0));
    check("m1_req_ready", 32'(m1_req_ready), 32'(g == 1));
    check("mem_addr", mem_addr, (g >= 0) ? ga : 32'h0);
    check("mem_we", 32'(mem_we), 32'(g >= 0 && gw && ok));
    if (g >= 0 && gw && ok) check("mem_wdata", mem_wdata, gd);
`ifdef DMEM_ARB_PERF_EN
    check("perf_grant0", perf_grant0, p_g0);
    check("perf_grant1", perf_grant1, p_g1);
    check("perf_err", perf_err, p_err);
`endif
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_last = 1; p_g0 = 0; p_g1 = 0; p_err = 0;
    end else if (g >= 0) begin
      m_rdata = (!gw && ok) ? model_mem[(ga - BASE) >> 2] : 32'h0;
      m_err   = !ok;
      if (gw && ok) model_mem[(ga - BASE) >> 2] = gd;
      m_busy = 1; m_owner = g; m_last = g;
      if (g == 0) p_g0++; else p_g1++;
      if (!ok) p_err++;
    end else if (m_busy && can) begin
      m_busy = 0;
    end
    last_g = g;
    @(negedge clk);
  endtask

  initial begin
    nvec = 0; nfail = 0; last_g = -1;
    m_busy = 0; m_owner = 0; m_last = 1; m_rdata = '0; m_err = 0;
    p_g0 = 0; p_g1 = 0; p_err = 0;
    rst = 1;
    {m0_req_valid, m0_req_we, m0_rsp_ready, m1_req_valid, m1_req_we, m1_rsp_ready} = '0;
    {m0_req_addr, m0_req_wdata, m1_req_addr, m1_req_wdata} = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m0_req_valid = 1; m1_req_valid = 1;
    step();  // reset state, requests ignored while in reset
    rst = 0; m0_req_valid = 0; m1_req_valid = 0;
    m0_rsp_ready = 1; m1_rsp_ready = 1;

    // Write then read back on port 0.
    m0_req_valid = 1; m0_req_addr = 32'h8000_0010; m0_req_we = 1; m0_req_wdata = 32'hDEAD_BEEF;
    step();
    check("t1_wr_rdata", m0_rsp_rdata, 32'h0);
    m0_req_we = 0;
    step();
    check("t1_rd_rdata", m0_rsp_rdata, 32'hDEAD_BEEF);
    m0_req_valid = 0;
    step();

    // Both ports requesting every cycle: strict alternation.
    m0_req_valid = 1; m1_req_valid = 1; m0_req_addr = BASE + 8; m1_req_addr = BASE + 12;
    m0_req_we = 0; m1_req_we = 1; m1_req_wdata = 32'h1234_5678;
    repeat (8) step();
    m0_req_valid = 0; m1_req_valid = 0;
    step();

    // Rejected writes on port 1.
    m1_req_valid = 1; m1_req_we = 1; m1_req_wdata = 32'hBAD0_BAD0;
    foreach (mem[i]) if (i < 3) begin
      m1_req_addr = (i == 0) ? 32'h7FFF_FFFC : (i == 1) ? BASE + 4 * MEM_SIZE : 32'h8000_0002;
      step();
      check("t3_err", 32'(m1_rsp_err), 32'h1);
    end
    m1_req_valid = 0;
    step();

    // Port 0 stalls its response while port 1 waits.
    m0_req_valid = 1; m0_req_addr = 32'h8000_0010; m0_req_we = 0; m0_rsp_ready = 0;
    step();
    m0_req_valid = 0; m1_req_valid = 1; m1_req_addr = BASE + 32; m1_req_we = 1;
    m1_req_wdata = 32'hCAFE_F00D;
    repeat (3) step();
    check("t4_hold", m0_rsp_rdata, 32'hDEAD_BEEF);
    m0_rsp_ready = 1;
    step();
    m1_req_valid = 0;
    step();

    // Reset while a response is held and port 1 presents a write.
    m0_req_valid = 1; m0_rsp_ready = 0;
    step();
    m0_req_valid = 0; m1_req_valid = 1; rst = 1;
    step();
    step();
    rst = 0; m0_rsp_ready = 1; m0_req_valid = 1;
    step();
    check("t5_first_tie_p0", 32'(last_g), 32'h0);
    m0_req_valid = 0; m1_req_valid = 0;
    step();

`ifdef DMEM_ARB_PERF_EN
    rst = 1;
    step();
    rst = 0;
    m0_req_valid = 1; m0_req_we = 0; m0_req_addr = BASE + 4;
    repeat (5) step();
    m0_req_valid = 0; m1_req_valid = 1; m1_req_we = 1;
    foreach (mem[i]) if (i < 3) begin
      m1_req_addr = (i == 0) ? BASE : BASE + 4 * MEM_SIZE + 4 * i;
      step();
    end
    m1_req_valid = 0;
    step();
    check("t6_grant0", perf_grant0, 32'd5);
    check("t6_grant1", perf_grant1, 32'd3);
    check("t6_err", perf_err, 32'd2);
    rst = 1;
    step();
    rst = 0;
    step();
    check("t6_clear", perf_grant0 | perf_grant1 | perf_err, 32'd0);
`endif

    // Randomized traffic; requests held until accepted.
    m0_req_valid = 0; m1_req_valid = 0; last_g = -1;
    for (int n = 0; n < 500; n++) begin
      if (!m0_req_valid || last_g == 0) begin
        m0_req_valid = $urandom_range(0, 2) != 0; m0_req_addr = rand_addr();
        m0_req_we = 1'($urandom_range(0, 1)); m0_req_wdata = $urandom;
      end
      if (!m1_req_valid || last_g == 1) begin
        m1_req_valid = $urandom_range(0, 2) != 0; m1_req_addr = rand_addr();
        m1_req_we = 1'($urandom_range(0, 1)); m1_req_wdata = $urandom;
      end
      m0_rsp_ready = $urandom_range(0, 3) != 0;
      m1_rsp_ready = $urandom_range(0, 3) != 0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
